// File: rtl/sram_wr_arbiter.sv
// sram_wr_arbiter: round-robin, packet-locked arbiter for the shared SRAM write path and null-page pool
// Ports: clk/rst_n (async active-low); wr_req/wr_last per-port page requests; wr_ack one-hot accept;
// wr_op/wr_port/wr_addr registered page write (null-page pop); null_ptr/free_space/page_amount from the
// SRAM state block; request_port selects the page_amount being queried; busy = locked; stall = locked
// port blocked by space or quota.
// Optional macro SRAM_WR_ARB_TIMEOUT_EN adds an idle timeout on the locked port and a timeout_abort pulse.
module sram_wr_arbiter #(
  parameter int PORT_NUM   = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int PORT_QUOTA = 1024,
  parameter int RESERVE    = 16
`ifdef SRAM_WR_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORT_NUM-1:0]         wr_req,
  input  logic [PORT_NUM-1:0]         wr_last,
  output logic [PORT_NUM-1:0]         wr_ack,
  output logic                        wr_op,
  output logic [$clog2(PORT_NUM)-1:0] wr_port,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [ADDR_WIDTH-1:0]       null_ptr,
  input  logic [ADDR_WIDTH-1:0]       free_space,
  output logic [$clog2(PORT_NUM)-1:0] request_port,
  input  logic [ADDR_WIDTH-1:0]       page_amount,
`ifdef SRAM_WR_ARB_TIMEOUT_EN
  output logic                        timeout_abort,
`endif
  output logic                        busy,
  output logic                        stall
);
  localparam int PW = $clog2(PORT_NUM);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, lock_port, winner, idx;
  logic found, accept, abort;
  logic [ADDR_WIDTH:0] eff_free, eff_amt;
  assign request_port = lock_port;
  assign busy = state == LOCK;
  // free_space and page_amount lag the write issued last cycle by one page
  assign eff_free = {1'b0, free_space} - {{ADDR_WIDTH{1'b0}}, wr_op};
  assign eff_amt = {1'b0, page_amount} + {{ADDR_WIDTH{1'b0}}, wr_op && wr_port == lock_port};
  assign accept = busy && wr_req[lock_port] && eff_free > (ADDR_WIDTH+1)'(RESERVE)
                  && eff_amt < (ADDR_WIDTH+1)'(PORT_QUOTA);
  assign stall = busy && wr_req[lock_port] && !accept;
  assign wr_ack = {{(PORT_NUM-1){1'b0}}, accept} << lock_port;
  assign wr_addr = wr_op ? null_ptr : '0;
  always_comb begin
    winner = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = rr_ptr + PW'(i);
      if (!found && wr_req[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = found ? LOCK : IDLE;
    else if ((accept && wr_last[lock_port]) || abort) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock_port <= '0;
      wr_op <= 1'b0;
      wr_port <= '0;
    end else begin
      state <= state_nxt;
      wr_op <= accept;
      wr_port <= lock_port;
      if (state == IDLE && found) begin
        lock_port <= winner;
        rr_ptr <= winner + 1'b1;
      end
    end
`ifdef SRAM_WR_ARB_TIMEOUT_EN
  logic [6:0] idle_cnt;
  // only cycles with no request from the locked port count as idle; stalls do not
  assign abort = busy && !accept && idle_cnt == 7'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout_abort <= 1'b0;
    end else begin
      idle_cnt <= (!busy || accept || abort) ? '0 : idle_cnt + {6'd0, !wr_req[lock_port]};
      timeout_abort <= abort;
    end
`else
  assign abort = 1'b0;
`endif
endmodule

// File: tb/tb_sram_wr_arbiter.sv
// tb_sram_wr_arbiter: directed bench with a write scoreboard for sram_wr_arbiter
module tb_sram_wr_arbiter;
  logic clk, rst_n;
  logic [15:0] wr_req, wr_last, wr_ack;
  logic wr_op, busy, stall;
  logic [3:0] wr_port, request_port;
  logic [10:0] wr_addr, null_ptr, free_space, page_amount;
`ifdef SRAM_WR_ARB_TIMEOUT_EN
  logic timeout_abort;
`endif
  int vectors = 0, miscompares = 0;
  logic [3:0] exp_q[$];
  sram_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_last(wr_last), .wr_ack(wr_ack),
    .wr_op(wr_op), .wr_port(wr_port), .wr_addr(wr_addr), .null_ptr(null_ptr),
    .free_space(free_space), .request_port(request_port), .page_amount(page_amount),
`ifdef SRAM_WR_ARB_TIMEOUT_EN
    .timeout_abort(timeout_abort),
`endif
    .busy(busy), .stall(stall)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one cycle: drive at negedge, check combinational outputs, log the expected write
  task automatic cyc(input logic [15:0] req, input logic [15:0] last, input int port,
                     input logic exp_busy, input logic exp_stall,
                     input logic [10:0] free, input logic [10:0] amt);
    @(negedge clk);
    wr_req = req;
    wr_last = last;
    free_space = free;
    page_amount = amt;
    null_ptr = 11'($urandom_range(0, 2047));
    #1;
    chk("wr_ack", wr_ack, port >= 0 ? 32'd1 << port : 32'd0);
    chk("busy", busy, exp_busy);
    chk("stall", stall, exp_stall);
    if (port >= 0) exp_q.push_back(4'(port));
  endtask
  task automatic do_reset(input logic [15:0] req);
    @(negedge clk);
    rst_n = 1'b0;
    wr_req = req;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_op", wr_op, 0);
    chk("rst_wr_ack", wr_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_req = '0;
    wr_last = '0;
  endtask
  // every write must match the oldest expected accept, and none may appear unannounced
  initial forever begin
    @(posedge clk);
    #2;
    if (wr_op) begin
      if (exp_q.size() == 0) chk("wr_op_unexpected", 1, 0);
      else begin
        chk("wr_port", wr_port, exp_q.pop_front());
        chk("wr_addr", wr_addr, null_ptr);
      end
    end else begin
      if (exp_q.size() != 0) begin
        chk("wr_op_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      chk("wr_addr_idle", wr_addr, 0);
    end
  end
  localparam logic [10:0] F = 11'd2047;
  initial begin
    logic [15:0] r;
    rst_n = 1'b0;
    wr_req = '0;
    wr_last = '0;
    null_ptr = '0;
    free_space = F;
    page_amount = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    chk("reset_wr_ack", wr_ack, 0);
    chk("reset_wr_op", wr_op, 0);
    chk("reset_wr_port", wr_port, 0);
    chk("reset_wr_addr", wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // four-page packet on port 3
    cyc(16'h0008, 16'h0000, -1, 0, 0, F, 0);
    cyc(16'h0008, 16'h0000, 3, 1, 0, F, 0);
    cyc(16'h0008, 16'h0000, 3, 1, 0, F, 0);
    cyc(16'h0008, 16'h0000, 3, 1, 0, F, 0);
    cyc(16'h0008, 16'h0008, 3, 1, 0, F, 0);
    cyc(16'h0000, 16'h0000, -1, 0, 0, F, 0);
    // round robin among 0, 5, 15 with single-page packets
    do_reset(16'h0000);
    r = 16'h8021;
    cyc(r, r, -1, 0, 0, F, 0);
    cyc(r, r, 0, 1, 0, F, 0);
    cyc(r, r, -1, 0, 0, F, 0);
    cyc(r, r, 5, 1, 0, F, 0);
    cyc(r, r, -1, 0, 0, F, 0);
    cyc(r, r, 15, 1, 0, F, 0);
    cyc(r, r, -1, 0, 0, F, 0);
    cyc(r, r, 0, 1, 0, F, 0);
    // free-space reserve boundary on port 2
    cyc(16'h0004, 16'h0000, -1, 0, 0, 17, 0);
    cyc(16'h0004, 16'h0000, 2, 1, 0, 17, 0);
    cyc(16'h0004, 16'h0000, -1, 1, 1, 17, 0);
    cyc(16'h0004, 16'h0000, -1, 1, 1, 16, 0);
    cyc(16'h0004, 16'h0004, 2, 1, 0, 18, 0);
    // port quota boundary on port 7
    cyc(16'h0080, 16'h0000, -1, 0, 0, F, 1023);
    cyc(16'h0080, 16'h0000, 7, 1, 0, F, 1023);
    cyc(16'h0080, 16'h0000, -1, 1, 1, F, 1023);
    cyc(16'h0080, 16'h0000, -1, 1, 1, F, 1024);
    cyc(16'h0080, 16'h0080, -1, 1, 1, F, 1024);
    // reset mid-packet on port 9, then rr_ptr restarts at 0
    do_reset(16'h0000);
    cyc(16'h0200, 16'h0000, -1, 0, 0, F, 0);
    cyc(16'h0200, 16'h0000, 9, 1, 0, F, 0);
    cyc(16'h0200, 16'h0000, 9, 1, 0, F, 0);
    do_reset(16'h0200);
    r = 16'h1002;
    cyc(r, 16'h0000, -1, 0, 0, F, 0);
    cyc(r, 16'h0002, 1, 1, 0, F, 0);
    cyc(r, 16'h0000, -1, 0, 0, F, 0);
    cyc(r, 16'h1000, 12, 1, 0, F, 0);
    cyc(16'h0000, 16'h0000, -1, 0, 0, F, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
